// File: rtl/id_ex_hazard_reg.sv
// ---------------------------------------------------------------------------
// id_ex_hazard_reg
//
// ID/EX pipeline register for the 5-stage MIPS datapath with load-use hazard
// detection and a saturating bubble counter.
//
// Every cycle the decoder's control bundle and the decoded operands are
// captured and presented to EX. When the instruction in EX is a load whose
// destination is read by the instruction in ID, or when ID is being flushed,
// a bubble (all-zero nop) is loaded instead.
//
// Ports:
//   clk, rst_n        rising-edge clock, synchronous active-low reset
//   id_*              control bundle, data and specifiers from ID
//   flush             squash the instruction in ID (taken branch/jump)
//   ex_*              registered EX-stage copies of every id_* input
//   stall             combinational; freeze PC and IF/ID when high
//   bubble_count      saturating count of inserted bubbles (reset not counted)
// ---------------------------------------------------------------------------
module id_ex_hazard_reg #(
    parameter int DW = 32,
    parameter int CW = 16
) (
    input  logic          clk,
    input  logic          rst_n,

    input  logic          id_RegDst,
    input  logic          id_Jump,
    input  logic          id_MemtoReg,
    input  logic          id_ALUSrc,
    input  logic          id_RegWrite,
    input  logic [1:0]    id_ALUOp,
    input  logic [1:0]    id_Branch,
    input  logic [1:0]    id_MemRead,
    input  logic [1:0]    id_MemWrite,
    input  logic [DW-1:0] id_pc4,
    input  logic [DW-1:0] id_rs_data,
    input  logic [DW-1:0] id_rt_data,
    input  logic [DW-1:0] id_imm,
    input  logic [4:0]    id_rs,
    input  logic [4:0]    id_rt,
    input  logic [4:0]    id_rd,
    input  logic [5:0]    id_funct,
    input  logic          flush,

    output logic          ex_RegDst,
    output logic          ex_Jump,
    output logic          ex_MemtoReg,
    output logic          ex_ALUSrc,
    output logic          ex_RegWrite,
    output logic [1:0]    ex_ALUOp,
    output logic [1:0]    ex_Branch,
    output logic [1:0]    ex_MemRead,
    output logic [1:0]    ex_MemWrite,
    output logic [DW-1:0] ex_pc4,
    output logic [DW-1:0] ex_rs_data,
    output logic [DW-1:0] ex_rt_data,
    output logic [DW-1:0] ex_imm,
    output logic [4:0]    ex_rs,
    output logic [4:0]    ex_rt,
    output logic [4:0]    ex_rd,
    output logic [5:0]    ex_funct,

    output logic          stall,
    output logic [CW-1:0] bubble_count
);

    logic hazard;
    logic bubble;

    // Load in EX whose destination ($rt) is a source of the ID instruction.
    // $0 is never a real dependency, and stores (MemRead = 00) never qualify.
    assign hazard = (ex_MemRead != 2'b00) & ex_RegWrite & (ex_rt != 5'd0) &
                    ((ex_rt == id_rs) | (ex_rt == id_rt));

    // A flush squashes the dependent instruction anyway, so holding fetch
    // would only block the redirect.
    assign stall  = hazard & ~flush;

    // One bubble per edge regardless of how many causes are active.
    assign bubble = flush | hazard;

    // Reset and bubble both load the all-zero nop.
    always_ff @(posedge clk) begin
        if (!rst_n || bubble) begin
            ex_RegDst   <= 1'b0;
            ex_Jump     <= 1'b0;
            ex_MemtoReg <= 1'b0;
            ex_ALUSrc   <= 1'b0;
            ex_RegWrite <= 1'b0;
            ex_ALUOp    <= 2'b00;
            ex_Branch   <= 2'b00;
            ex_MemRead  <= 2'b00;
            ex_MemWrite <= 2'b00;
            ex_pc4      <= '0;
            ex_rs_data  <= '0;
            ex_rt_data  <= '0;
            ex_imm      <= '0;
            ex_rs       <= 5'd0;
            ex_rt       <= 5'd0;
            ex_rd       <= 5'd0;
            ex_funct    <= 6'd0;
        end else begin
            ex_RegDst   <= id_RegDst;
            ex_Jump     <= id_Jump;
            ex_MemtoReg <= id_MemtoReg;
            ex_ALUSrc   <= id_ALUSrc;
            ex_RegWrite <= id_RegWrite;
            ex_ALUOp    <= id_ALUOp;
            ex_Branch   <= id_Branch;
            ex_MemRead  <= id_MemRead;
            ex_MemWrite <= id_MemWrite;
            ex_pc4      <= id_pc4;
            ex_rs_data  <= id_rs_data;
            ex_rt_data  <= id_rt_data;
            ex_imm      <= id_imm;
            ex_rs       <= id_rs;
            ex_rt       <= id_rt;
            ex_rd       <= id_rd;
            ex_funct    <= id_funct;
        end
    end

    // Saturating bubble counter; reset-induced clears are not bubbles.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            bubble_count <= '0;
        end else if (bubble && (bubble_count != {CW{1'b1}})) begin
            bubble_count <= bubble_count + CW'(1);
        end
    end

endmodule

// File: tb/tb_id_ex_hazard_reg.sv
// ---------------------------------------------------------------------------
// tb_id_ex_hazard_reg
//
// Directed and randomized stimulus for id_ex_hazard_reg (DW = 32, CW = 4).
// The reference model tracks "the instruction currently in EX" as a whole
// record plus an integer bubble tally, and applies the load-use rule to it.
// ---------------------------------------------------------------------------
module tb_id_ex_hazard_reg;

    localparam int DW  = 32;
    localparam int CW  = 4;
    localparam int SAT = (1 << CW) - 1;

    typedef struct packed {
        logic        RegDst;
        logic        Jump;
        logic        MemtoReg;
        logic        ALUSrc;
        logic        RegWrite;
        logic [1:0]  ALUOp;
        logic [1:0]  Branch;
        logic [1:0]  MemRead;
        logic [1:0]  MemWrite;
        logic [31:0] pc4;
        logic [31:0] rs_data;
        logic [31:0] rt_data;
        logic [31:0] imm;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  rd;
        logic [5:0]  funct;
    } instr_t;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          flush = 1'b0;
    instr_t        id = '0;
    instr_t        dex;
    logic          stall;
    logic [CW-1:0] bubble_count;

    logic          ex_RegDst, ex_Jump, ex_MemtoReg, ex_ALUSrc, ex_RegWrite;
    logic [1:0]    ex_ALUOp, ex_Branch, ex_MemRead, ex_MemWrite;
    logic [DW-1:0] ex_pc4, ex_rs_data, ex_rt_data, ex_imm;
    logic [4:0]    ex_rs, ex_rt, ex_rd;
    logic [5:0]    ex_funct;

    always #5 clk = ~clk;

    id_ex_hazard_reg #(.DW(DW), .CW(CW)) dut (
        .clk(clk), .rst_n(rst_n),
        .id_RegDst(id.RegDst), .id_Jump(id.Jump), .id_MemtoReg(id.MemtoReg),
        .id_ALUSrc(id.ALUSrc), .id_RegWrite(id.RegWrite), .id_ALUOp(id.ALUOp),
        .id_Branch(id.Branch), .id_MemRead(id.MemRead), .id_MemWrite(id.MemWrite),
        .id_pc4(id.pc4), .id_rs_data(id.rs_data), .id_rt_data(id.rt_data),
        .id_imm(id.imm), .id_rs(id.rs), .id_rt(id.rt), .id_rd(id.rd),
        .id_funct(id.funct), .flush(flush),
        .ex_RegDst(ex_RegDst), .ex_Jump(ex_Jump), .ex_MemtoReg(ex_MemtoReg),
        .ex_ALUSrc(ex_ALUSrc), .ex_RegWrite(ex_RegWrite), .ex_ALUOp(ex_ALUOp),
        .ex_Branch(ex_Branch), .ex_MemRead(ex_MemRead), .ex_MemWrite(ex_MemWrite),
        .ex_pc4(ex_pc4), .ex_rs_data(ex_rs_data), .ex_rt_data(ex_rt_data),
        .ex_imm(ex_imm), .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_rd(ex_rd),
        .ex_funct(ex_funct),
        .stall(stall), .bubble_count(bubble_count)
    );

    assign dex = {ex_RegDst, ex_Jump, ex_MemtoReg, ex_ALUSrc, ex_RegWrite,
                  ex_ALUOp, ex_Branch, ex_MemRead, ex_MemWrite,
                  ex_pc4, ex_rs_data, ex_rt_data, ex_imm,
                  ex_rs, ex_rt, ex_rd, ex_funct};

    // Reference state: what instruction sits in EX, and how many bubbles so far.
    instr_t mex;
    int     mcnt;
    bit     known = 0;
    int     vectors = 0;
    int     fails = 0;
    logic   last_stall;

    // The EX instruction is a load writing a nonzero register that ID reads.
    function automatic bit load_use(instr_t ex_i, instr_t id_i);
        bit is_load = (ex_i.MemRead != 2'b00) && ex_i.RegWrite;
        bit reads   = (id_i.rs == ex_i.rt) || (id_i.rt == ex_i.rt);
        return is_load && (ex_i.rt != 0) && reads;
    endfunction

    function automatic instr_t rtype(int rs, int rt, int rd);
        instr_t r = '0;
        r.RegDst = 1; r.RegWrite = 1;
        r.rs = 5'(rs); r.rt = 5'(rt); r.rd = 5'(rd);
        r.funct = 6'h20;
        r.rs_data = $urandom; r.rt_data = $urandom; r.pc4 = $urandom;
        return r;
    endfunction

    function automatic instr_t load(int width, int rs, int rt);
        instr_t r = '0;
        r.MemRead = 2'(width); r.RegWrite = 1; r.ALUSrc = 1; r.MemtoReg = 1;
        r.rs = 5'(rs); r.rt = 5'(rt);
        r.imm = $urandom; r.rs_data = $urandom; r.pc4 = $urandom;
        return r;
    endfunction

    function automatic instr_t rnd_instr();
        instr_t r;
        r.RegDst = 1'($urandom_range(0, 1));  r.Jump = 1'($urandom_range(0, 1));
        r.MemtoReg = 1'($urandom_range(0, 1)); r.ALUSrc = 1'($urandom_range(0, 1));
        r.RegWrite = 1'($urandom_range(0, 1));
        r.ALUOp = 2'($urandom_range(0, 3));   r.Branch = 2'($urandom_range(0, 3));
        r.MemRead = 2'($urandom_range(0, 3)); r.MemWrite = 2'($urandom_range(0, 3));
        r.pc4 = $urandom; r.rs_data = $urandom; r.rt_data = $urandom; r.imm = $urandom;
        r.rs = 5'($urandom_range(0, 3)); r.rt = 5'($urandom_range(0, 3));
        r.rd = 5'($urandom); r.funct = 6'($urandom);
        return r;
    endfunction

    // One cycle: present ID inputs, check stall mid-cycle, clock, check EX.
    task automatic step(string tag, instr_t ins, logic fl, logic rn);
        bit hz;
        logic exp_stall;
        id = ins; flush = fl; rst_n = rn;
        vectors++;
        #1;
        hz = known && load_use(mex, ins);
        exp_stall = hz && !fl;
        if (known) begin
            assert (stall === exp_stall) else begin
                fails++;
                $error("FAIL %s stall observed=%b expected=%b", tag, stall, exp_stall);
            end
        end
        last_stall = exp_stall;
        @(posedge clk);
        #1;
        if (!rn) begin
            mex = '0; mcnt = 0; known = 1;
        end else if (fl || hz) begin
            mex = '0;
            if (mcnt < SAT) mcnt++;
        end else begin
            mex = ins;
        end
        assert (dex === mex) else begin
            fails++;
            $error("FAIL %s ex observed=%h expected=%h", tag, dex, mex);
        end
        assert (bubble_count === CW'(mcnt)) else begin
            fails++;
            $error("FAIL %s bubble_count observed=%0d expected=%0d", tag, bubble_count, mcnt);
        end
    endtask

    initial begin
        instr_t r, held;
        bit     hold;

        // Reset with arbitrary ID inputs for two edges.
        step("reset0", rnd_instr(), 1'b0, 1'b0);
        step("reset1", rnd_instr(), 1'b1, 1'b0);

        // Pass-through of an R-type.
        r = rtype(8, 9, 10);
        r.rs_data = 32'h0000_0005; r.pc4 = 32'h0000_0044;
        step("pass", r, 1'b0, 1'b1);
        assert (ex_rs_data === 32'h0000_0005 && ex_pc4 === 32'h0000_0044) else begin
            fails++;
            $error("FAIL pass_data observed=%h/%h expected=00000005/00000044", ex_rs_data, ex_pc4);
        end

        // Load-use: lw $9 then consumer of $9, re-presented after the stall.
        step("lu_lw", load(1, 2, 9), 1'b0, 1'b1);
        r = rtype(9, 3, 11);
        step("lu_stall", r, 1'b0, 1'b1);
        step("lu_retry", r, 1'b0, 1'b1);

        // Both operands match the load destination: still a single bubble.
        step("both_lw", load(1, 2, 7), 1'b0, 1'b1);
        r = rtype(7, 7, 12);
        step("both_stall", r, 1'b0, 1'b1);
        step("both_retry", r, 1'b0, 1'b1);

        // No-hazard cases.
        step("lw0", load(1, 4, 0), 1'b0, 1'b1);
        step("lw0_use", rtype(0, 0, 13), 1'b0, 1'b1);
        r = load(0, 4, 6); r.MemtoReg = 0; r.RegWrite = 0; r.MemWrite = 2'b10;
        step("sb", r, 1'b0, 1'b1);
        step("sb_use", rtype(6, 6, 14), 1'b0, 1'b1);
        step("lh", load(3, 1, 4), 1'b0, 1'b1);
        step("lh_use", rtype(5, 6, 15), 1'b0, 1'b1);

        // Flush overrides the stall; bubble counted once.
        step("fl_lw", load(1, 2, 3), 1'b0, 1'b1);
        step("fl_use", rtype(3, 1, 16), 1'b1, 1'b1);

        // Reset while a stall is active: no count, registers clear.
        step("rs_lw", load(2, 2, 5), 1'b0, 1'b1);
        step("rs_stall", rtype(5, 0, 17), 1'b0, 1'b0);

        // Randomized traffic; a stalled instruction is held upstream.
        hold = 0; held = '0;
        for (int i = 0; i < 400; i++) begin
            r = hold ? held : rnd_instr();
            step("rand", r, ($urandom_range(0, 7) == 0), ($urandom_range(0, 63) != 0));
            hold = last_stall;
            held = r;
        end

        // Saturation: 17 load-use bubbles from a clean counter.
        step("sat_rst", rnd_instr(), 1'b0, 1'b0);
        for (int i = 0; i < 17; i++) begin
            step("sat_lw", load(1, 0, 2), 1'b0, 1'b1);
            step("sat_use", rtype(2, 0, 1), 1'b0, 1'b1);
        end
        assert (bubble_count === CW'(SAT)) else begin
            fails++;
            $error("FAIL sat_value observed=%0d expected=%0d", bubble_count, SAT);
        end
        step("sat_hold", rtype(2, 0, 1), 1'b1, 1'b1);
        step("sat_clr", rnd_instr(), 1'b0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
        $finish;
    end

endmodule

// File: doc/id_ex_hazard_reg.md
# id_ex_hazard_reg

ID/EX pipeline register with built-in load-use hazard detection for the 5-stage MIPS datapath. It sits directly downstream of the opcode control decoder and the register file. It captures the decoder's control bundle plus the decoded operands every cycle and presents them to the EX stage. On a load-use hazard or a pipeline flush it inserts a bubble in place of the decoded instruction, and it counts the bubbles it inserts.

## Interface
Parameters:
- DW, 32, datapath width (PC+4, register operands, sign-extended immediate)
- CW, 16, bubble-counter width

Ports:
- clk  in  1  rising-edge clock (only clock)
- rst_n  in  1  synchronous active-low reset
- id_RegDst, id_Jump, id_MemtoReg, id_ALUSrc, id_RegWrite  in  1 each  control from decoder
- id_ALUOp, id_Branch, id_MemRead, id_MemWrite  in  2 each  control from decoder (MemRead/MemWrite: 00 none, 01 word, 10 byte, 11 half)
- id_pc4, id_rs_data, id_rt_data, id_imm  in  DW each  ID-stage data
- id_rs, id_rt, id_rd  in  5 each  register specifiers of the instruction in ID
- id_funct  in  6  function field
- flush  in  1  squash the instruction in ID (taken branch/jump)
- ex_* (same names/widths as every id_* input)  out  registered EX-stage copies
- stall  out  1  combinational; freeze PC and IF/ID when high
- bubble_count  out  CW  saturating count of inserted bubbles

## Operation
- Control bundle: RegDst, Jump, Branch, MemRead, MemtoReg, ALUOp, MemWrite, ALUSrc, RegWrite.
- Hazard detection, combinational from registered EX state and the ID inputs:
  - hazard = (ex_MemRead != 00) & ex_RegWrite & (ex_rt != 0) & ((ex_rt == id_rs) | (ex_rt == id_rt)).
- stall = hazard & ~flush. A flush overrides the stall so the fetch redirect proceeds.
- Per-edge update, priority order:
  1. rst_n low: every ex_* output = 0 and bubble_count = 0.
  2. flush: load a bubble.
  3. hazard: load a bubble.
  4. otherwise: every ex_* = its id_* counterpart.
- Bubble definition: every control output = 0 and every data/specifier output = 0. The result is a nop: no register write and no memory access.
- bubble_count increments by 1 on each edge that loads a bubble because of flush or hazard.
  - Increments at most once per cycle, even when flush and hazard coincide.
  - Saturates at 2^CW-1 and does not wrap.
  - Reset bubbles are not counted.
- Load-use sequence:
  - The stalled instruction is held upstream (IF/ID frozen by stall) and is re-presented on the next cycle.
  - By then ex_ holds the bubble, so hazard is 0 and the instruction enters EX.
  - Exactly one bubble per load-use pair.
- Stores do not trigger a hazard: ex_MemRead = 00.
- Loads to $0 do not trigger a hazard (ex_rt == 0 check).
- Both-operand match (id_rs == id_rt == ex_rt): a single one-cycle stall.
- No state machine beyond the registers and the counter. The block holds no internal pending state.

## Timing
- Latency 1 cycle: id_* sampled at rising edge N appear on ex_* after edge N.
- stall is valid in the same cycle the ID inputs are valid. It is a combinational path from id_rs/id_rt/flush and registered ex_rt/ex_MemRead/ex_RegWrite.
- Reset is synchronous: it takes effect only at a clock edge while rst_n = 0.
  - Outputs are 0 from the first edge with rst_n low.
  - stall reads 0 after that edge because ex_MemRead = 00.
- Reset mid-stall: the next edge clears ex_*. stall drops to 0 in the same cycle the registers clear, and the counter does not increment on that edge.
- Flush while ex_ holds a load: the edge loads a bubble and increments the counter once. stall stays 0 throughout.
- bubble_count updates on the same edge as the bubble load.

## Test plan
- Reset: hold rst_n = 0 for 2 edges with arbitrary id_* -> all ex_* = 0, bubble_count = 0, stall = 0.
- Pass-through, with rst_n = 1:
  - Stimulus: R-type bundle (RegDst = 1, RegWrite = 1, ALUOp = 00, others 0), id_rs = 8, id_rt = 9, id_rd = 10, id_rs_data = 32'h0000_0005, id_pc4 = 32'h0000_0044.
  - Next edge: same values on ex_*, stall = 0, bubble_count unchanged.
- Load-use:
  - Stimulus: lw (MemRead = 01, RegWrite = 1, ALUSrc = 1, MemtoReg = 1, id_rt = 9), followed by an R-type with id_rs = 9.
  - Cycle after the lw edge: stall = 1.
  - Next edge: ex_* all 0 and bubble_count = 1.
  - Following cycle: stall = 0, and the R-type reaches ex_ on the next edge.
- No-hazard cases, each -> stall = 0, no bubble:
  - lw with id_rt = 0 followed by a consumer of $0.
  - sb (MemWrite = 10) followed by a consumer of its rt.
  - lh to rt = 4 followed by a consumer of rs = 5, rt = 6.
- Flush priority:
  - Stimulus: ex_ holds lw to rt = 3, ID instruction uses rs = 3, flush = 1.
  - Response: stall = 0, next edge loads a bubble, bubble_count increments by exactly 1.
- Saturation: CW = 4, generate 17 hazard bubbles -> bubble_count = 15 and stays 15. Reset -> bubble_count = 0.
